multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control FSM for the multicycle RV32I core. It sequences the shared datapath (one ALU, one memory port, ALUOut/IR/PC registers) through fetch, decode, execute, memory and writeback. It also drives the 3-bit ALUOp class code consumed by the ALU control decoder. It sits between the instruction register fields and all datapath enables and mux selects, and waits on a memory ready handshake.

## Interface
- No parameters.
- CLK  in  1  core clock; all state changes on rising edge
- RESET  in  1  synchronous, active-high reset
- opcode  in  7  IR[6:0]
- funct3_0  in  1  IR[12]; 0 = BEQ, 1 = BNE
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request, held until mem_ready
- mem_write  out  1  store qualifier (valid only with mem_req)
- adr_src  out  1  address mux: 0 = PC, 1 = ALUOut
- ir_write  out  1  load IR and oldPC
- pc_write  out  1  load PC from result mux
- reg_write  out  1  register file write of rd
- alu_src_a  out  2  00 = PC, 01 = oldPC, 10 = rs1, 11 = zero
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4
- result_src  out  2  00 = ALUOut, 01 = memory data, 10 = live ALU result
- alu_op  out  3  000 = R, 001 = branch, 010 = add (load/store/address), 011 = I-ALU, 100 = LUI/AUIPC
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal_instr  out  1  sticky illegal-opcode flag

## Operation
- Moore FSM. All outputs are decoded from the state register only, except pc_write in BRANCH and the mem_ready-qualified strobes. Unlisted outputs are 0, and alu_src/result_src/alu_op default to 00/00/000.
- FETCH: mem_req, adr_src=0, a=00, b=10, op=010, result_src=10; ir_write=pc_write=mem_ready. Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: a=01, b=01, op=010 (branch/JAL target into ALUOut). Next state by opcode:
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 0000011 or 0100011 → MEMADR
  - 1100011 → BRANCH
  - 1101111 → JUMP
  - 1100111 → JALRADR
  - 0110111 or 0010111 → UPPER
  - any other opcode → TRAP
- MEMADR: a=10, b=01, op=010. Goes to MEMREAD if opcode=0000011, else MEMWRITE.
- MEMREAD: mem_req, adr_src=1. Goes to MEMWB on mem_ready.
- MEMWB: result_src=01, reg_write, instr_done. Goes to FETCH.
- MEMWRITE: mem_req, mem_write, adr_src=1. On mem_ready: instr_done, then FETCH.
- EXECR: a=10, b=00, op=000. Goes to ALUWB.
- EXECI: a=10, b=01, op=011. Goes to ALUWB.
- UPPER: b=01, op=100; a=11 for LUI (0110111), a=01 for AUIPC. Goes to ALUWB.
- ALUWB: result_src=00, reg_write, instr_done. Goes to FETCH.
- BRANCH: a=10, b=00, op=001, result_src=00, pc_write=(zero XOR funct3_0), instr_done. Goes to FETCH.
- JALRADR: a=10, b=01, op=010. Goes to JUMP.
- JUMP: result_src=00, pc_write=1, a=01, b=10, op=010 (oldPC+4 into ALUOut). Goes to ALUWB.
- TRAP: all enables 0; illegal_instr=1. Stays in TRAP until RESET.

## Timing
- With RESET high at a clock edge, the state becomes FETCH and illegal_instr is cleared.
- While RESET is high, every output is forced to 0, including mem_req.
- The first fetch request appears in the cycle after RESET deasserts.
- Cycles per instruction, zero memory wait states:
  - load 5
  - store 4
  - R, I, LUI/AUIPC 4
  - branch 3
  - JAL 4
  - JALR 5
- Each wait cycle adds 1 in FETCH, MEMREAD or MEMWRITE.
- Handshake: mem_req, adr_src and mem_write stay stable until the cycle in which mem_ready=1. mem_ready while mem_req=0 is ignored.
- ir_write and pc_write in FETCH are asserted only in the mem_ready cycle. Exactly one pulse per fetch.
- instr_done pulses exactly once per instruction and never in TRAP.
- RESET in any state, including mid-wait in MEMWRITE, aborts the instruction. No write strobe is asserted in that cycle.

## Test plan
- **Reset:** assert RESET for 2 cycles mid-MEMWRITE → all outputs 0 during reset; state FETCH with mem_req=1 one cycle after release.
- **ADD (opcode 0110011), mem_ready always 1:** sequence FETCH, DECODE, EXECR (alu_op=000), ALUWB (reg_write=1); instr_done at cycle 4.
- **LW with 2 wait cycles on the data access:** MEMREAD held 3 cycles with mem_req=1 and adr_src=1; MEMWB asserts result_src=01 and reg_write=1; 7 cycles total.
- **BEQ:** zero=1, funct3_0=0 → pc_write=1 in BRANCH. BNE with zero=1 → pc_write=0. alu_op=001 in both; 3 cycles.
- **JALR then LUI:** JALRADR → JUMP (pc_write=1, alu_src_a=01, alu_src_b=10) → ALUWB. LUI: UPPER with alu_op=100 and alu_src_a=11.
- **Opcode 1111111:** TRAP; illegal_instr stays 1, no mem_req, no instr_done over 10 cycles; cleared by RESET.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback over the shared datapath.
module multicycle_control (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [6:0] opcode,
  input  logic       funct3_0,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] alu_op,
  output logic       instr_done,
  output logic       illegal_instr
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_UPPER, S_ALUWB, S_BRANCH, S_JALRADR, S_JUMP, S_TRAP
  } state_t;

  state_t state;
  logic   illegal_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH:    if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_R:               state <= S_EXECR;
            OP_I:               state <= S_EXECI;
            OP_LOAD, OP_STORE:  state <= S_MEMADR;
            OP_BRANCH:          state <= S_BRANCH;
            OP_JAL:             state <= S_JUMP;
            OP_JALR:            state <= S_JALRADR;
            OP_LUI, OP_AUIPC:   state <= S_UPPER;
            default: begin
              state     <= S_TRAP;
              illegal_q <= 1'b1;
            end
          endcase
        end
        S_MEMADR:   state <= (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWRITE: if (mem_ready) state <= S_FETCH;
        S_EXECR, S_EXECI, S_UPPER: state <= S_ALUWB;
        S_JALRADR:  state <= S_JUMP;
        S_JUMP:     state <= S_ALUWB;
        S_MEMWB, S_ALUWB, S_BRANCH: state <= S_FETCH;
        S_TRAP:     state <= S_TRAP;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Outputs decode from the state register; only the memory strobes and the
  // branch pc_write look at inputs. RESET forces everything quiet.
  always_comb begin
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    result_src    = 2'b00;
    alu_op        = 3'b000;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;
    if (!RESET) begin
      illegal_instr = illegal_q;
      case (state)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = 2'b10;
          alu_op     = 3'b010;
          result_src = 2'b10;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          alu_op    = 3'b010;
        end
        S_MEMADR, S_JALRADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          alu_op    = 3'b010;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req    = 1'b1;
          mem_write  = 1'b1;
          adr_src    = 1'b1;
          instr_done = mem_ready;
        end
        S_EXECR: begin
          alu_src_a = 2'b10;
        end
        S_EXECI: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          alu_op    = 3'b011;
        end
        S_UPPER: begin
          alu_src_a = (opcode == OP_LUI) ? 2'b11 : 2'b01;
          alu_src_b = 2'b01;
          alu_op    = 3'b100;
        end
        S_ALUWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  = 2'b10;
          alu_op     = 3'b001;
          pc_write   = zero ^ funct3_0;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          alu_op    = 3'b010;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control: steps the FSM one cycle at a time
// and compares the full output bundle against hand-written expectations.
module tb_multicycle_control;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [6:0] opcode;
  logic       funct3_0, zero, mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] alu_op;
  logic       instr_done, illegal_instr;

  int errors = 0;
  int checks = 0;

  multicycle_control dut (
    .CLK(CLK), .RESET(RESET), .opcode(opcode), .funct3_0(funct3_0),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .result_src(result_src), .alu_op(alu_op),
    .instr_done(instr_done), .illegal_instr(illegal_instr)
  );

  always #5 CLK = ~CLK;

  // Bundle order: mem_req mem_write adr_src ir_write pc_write reg_write
  //               alu_src_a alu_src_b result_src alu_op instr_done illegal_instr
  function automatic logic [16:0] pack(input logic mreq, mw, adr, irw, pcw, rw,
                                       input logic [1:0] a, b, rs,
                                       input logic [2:0] op,
                                       input logic done, ill);
    return {mreq, mw, adr, irw, pcw, rw, a, b, rs, op, done, ill};
  endfunction

  localparam logic [16:0] E_RESET    = 17'd0;
  localparam logic [16:0] E_FETCH_W  = {6'b100000, 2'b00, 2'b10, 2'b10, 3'b010, 2'b00};
  localparam logic [16:0] E_FETCH_R  = {6'b100110, 2'b00, 2'b10, 2'b10, 3'b010, 2'b00};
  localparam logic [16:0] E_DECODE   = {6'b000000, 2'b01, 2'b01, 2'b00, 3'b010, 2'b00};
  localparam logic [16:0] E_EXECR    = {6'b000000, 2'b10, 2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [16:0] E_EXECI    = {6'b000000, 2'b10, 2'b01, 2'b00, 3'b011, 2'b00};
  localparam logic [16:0] E_ALUWB    = {6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b10};
  localparam logic [16:0] E_MEMADR   = {6'b000000, 2'b10, 2'b01, 2'b00, 3'b010, 2'b00};
  localparam logic [16:0] E_MEMREAD  = {6'b101000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [16:0] E_MEMWB    = {6'b000001, 2'b00, 2'b00, 2'b01, 3'b000, 2'b10};
  localparam logic [16:0] E_MEMWR_W  = {6'b111000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [16:0] E_MEMWR_R  = {6'b111000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b10};
  localparam logic [16:0] E_BR_TAKEN = {6'b000010, 2'b10, 2'b00, 2'b00, 3'b001, 2'b10};
  localparam logic [16:0] E_BR_NOT   = {6'b000000, 2'b10, 2'b00, 2'b00, 3'b001, 2'b10};
  localparam logic [16:0] E_JALRADR  = {6'b000000, 2'b10, 2'b01, 2'b00, 3'b010, 2'b00};
  localparam logic [16:0] E_JUMP     = {6'b000010, 2'b01, 2'b10, 2'b00, 3'b010, 2'b00};
  localparam logic [16:0] E_LUI      = {6'b000000, 2'b11, 2'b01, 2'b00, 3'b100, 2'b00};
  localparam logic [16:0] E_AUIPC    = {6'b000000, 2'b01, 2'b01, 2'b00, 3'b100, 2'b00};
  localparam logic [16:0] E_TRAP     = {6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01};

  // Drive inputs on the falling edge so the next rising edge sees them settled.
  task automatic apply_stimulus(input logic rst, input logic [6:0] op,
                                input logic f3, z, rdy);
    @(negedge CLK);
    RESET     = rst;
    opcode    = op;
    funct3_0  = f3;
    zero      = z;
    mem_ready = rdy;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [16:0] expected);
    logic [16:0] observed;
    observed = pack(mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                    alu_src_a, alu_src_b, result_src, alu_op, instr_done,
                    illegal_instr);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%05h expected=%05h", tag, observed, expected);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic [6:0] op,
                      input logic f3, z, rdy, input logic [16:0] expected);
    apply_stimulus(rst, op, f3, z, rdy);
    check_output(tag, expected);
  endtask

  initial begin
    RESET = 1'b1; opcode = 7'd0; funct3_0 = 1'b0; zero = 1'b0; mem_ready = 1'b0;

    step("reset0", 1, 7'b0110011, 0, 0, 0, E_RESET);
    step("reset1", 1, 7'b0110011, 0, 0, 1, E_RESET);

    // ADD, no wait states: 4 cycles
    step("add_fetch",  0, 7'b0110011, 0, 0, 1, E_FETCH_R);
    step("add_decode", 0, 7'b0110011, 0, 0, 1, E_DECODE);
    step("add_execr",  0, 7'b0110011, 0, 0, 1, E_EXECR);
    step("add_aluwb",  0, 7'b0110011, 0, 0, 1, E_ALUWB);

    // LW with two data wait cycles: 7 cycles
    step("lw_fetch",  0, 7'b0000011, 0, 0, 1, E_FETCH_R);
    step("lw_decode", 0, 7'b0000011, 0, 0, 1, E_DECODE);
    step("lw_memadr", 0, 7'b0000011, 0, 0, 1, E_MEMADR);
    step("lw_wait0",  0, 7'b0000011, 0, 0, 0, E_MEMREAD);
    step("lw_wait1",  0, 7'b0000011, 0, 0, 0, E_MEMREAD);
    step("lw_ready",  0, 7'b0000011, 0, 0, 1, E_MEMREAD);
    step("lw_memwb",  0, 7'b0000011, 0, 0, 1, E_MEMWB);

    // SW with one fetch wait and one store wait
    step("sw_fetchw", 0, 7'b0100011, 0, 0, 0, E_FETCH_W);
    step("sw_fetch",  0, 7'b0100011, 0, 0, 1, E_FETCH_R);
    step("sw_decode", 0, 7'b0100011, 0, 0, 1, E_DECODE);
    step("sw_memadr", 0, 7'b0100011, 0, 0, 1, E_MEMADR);
    step("sw_wait",   0, 7'b0100011, 0, 0, 0, E_MEMWR_W);
    step("sw_done",   0, 7'b0100011, 0, 0, 1, E_MEMWR_R);

    // BEQ taken then BNE not taken, both with zero=1
    step("beq_fetch",  0, 7'b1100011, 0, 1, 1, E_FETCH_R);
    step("beq_decode", 0, 7'b1100011, 0, 1, 1, E_DECODE);
    step("beq_branch", 0, 7'b1100011, 0, 1, 1, E_BR_TAKEN);
    step("bne_fetch",  0, 7'b1100011, 1, 1, 1, E_FETCH_R);
    step("bne_decode", 0, 7'b1100011, 1, 1, 1, E_DECODE);
    step("bne_branch", 0, 7'b1100011, 1, 1, 1, E_BR_NOT);

    // ADDI
    step("addi_fetch",  0, 7'b0010011, 0, 0, 1, E_FETCH_R);
    step("addi_decode", 0, 7'b0010011, 0, 0, 1, E_DECODE);
    step("addi_execi",  0, 7'b0010011, 0, 0, 1, E_EXECI);
    step("addi_aluwb",  0, 7'b0010011, 0, 0, 1, E_ALUWB);

    // JALR: 5 cycles
    step("jalr_fetch",  0, 7'b1100111, 0, 0, 1, E_FETCH_R);
    step("jalr_decode", 0, 7'b1100111, 0, 0, 1, E_DECODE);
    step("jalr_adr",    0, 7'b1100111, 0, 0, 1, E_JALRADR);
    step("jalr_jump",   0, 7'b1100111, 0, 0, 1, E_JUMP);
    step("jalr_aluwb",  0, 7'b1100111, 0, 0, 1, E_ALUWB);

    // JAL: 4 cycles
    step("jal_fetch",  0, 7'b1101111, 0, 0, 1, E_FETCH_R);
    step("jal_decode", 0, 7'b1101111, 0, 0, 1, E_DECODE);
    step("jal_jump",   0, 7'b1101111, 0, 0, 1, E_JUMP);
    step("jal_aluwb",  0, 7'b1101111, 0, 0, 1, E_ALUWB);

    // LUI and AUIPC differ only in alu_src_a
    step("lui_fetch",    0, 7'b0110111, 0, 0, 1, E_FETCH_R);
    step("lui_decode",   0, 7'b0110111, 0, 0, 1, E_DECODE);
    step("lui_upper",    0, 7'b0110111, 0, 0, 1, E_LUI);
    step("lui_aluwb",    0, 7'b0110111, 0, 0, 1, E_ALUWB);
    step("auipc_fetch",  0, 7'b0010111, 0, 0, 1, E_FETCH_R);
    step("auipc_decode", 0, 7'b0010111, 0, 0, 1, E_DECODE);
    step("auipc_upper",  0, 7'b0010111, 0, 0, 1, E_AUIPC);
    step("auipc_aluwb",  0, 7'b0010111, 0, 0, 1, E_ALUWB);

    // Reset while a store is waiting: nothing may strobe, then a fresh fetch
    step("rsw_fetch",  0, 7'b0100011, 0, 0, 1, E_FETCH_R);
    step("rsw_decode", 0, 7'b0100011, 0, 0, 1, E_DECODE);
    step("rsw_memadr", 0, 7'b0100011, 0, 0, 1, E_MEMADR);
    step("rsw_wait",   0, 7'b0100011, 0, 0, 0, E_MEMWR_W);
    step("rsw_reset0", 1, 7'b0100011, 0, 0, 1, E_RESET);
    step("rsw_reset1", 1, 7'b0100011, 0, 0, 1, E_RESET);
    step("rsw_refetch", 0, 7'b0100011, 0, 0, 0, E_FETCH_W);
    step("rsw_refetch_rdy", 0, 7'b0110011, 0, 0, 1, E_FETCH_R);
    step("rsw_decode2", 0, 7'b0110011, 0, 0, 1, E_DECODE);
    step("rsw_execr",   0, 7'b0110011, 0, 0, 1, E_EXECR);
    step("rsw_aluwb",   0, 7'b0110011, 0, 0, 1, E_ALUWB);

    // Illegal opcode: trap is sticky and ignores mem_ready
    step("ill_fetch",  0, 7'b1111111, 0, 0, 1, E_FETCH_R);
    step("ill_decode", 0, 7'b1111111, 0, 0, 1, E_DECODE);
    for (int i = 0; i < 10; i++)
      step($sformatf("ill_trap%0d", i), 0, 7'b1111111, 0, i[0], i[1], E_TRAP);
    step("ill_reset", 1, 7'b1111111, 0, 0, 1, E_RESET);
    step("ill_after", 0, 7'b0110011, 0, 0, 0, E_FETCH_W);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
